// File: rtl/gpu_line_drawer_if.sv
// Command/pixel bundle between the command decoder, the line drawer and the framebuffer writer.
// Signal suffixes are named from the line drawer's point of view.
interface gpu_line_drawer_if;
    logic [9:0]  x1_i;
    logic [8:0]  y1_i;
    logic [9:0]  x2_i;
    logic [8:0]  y2_i;
    logic [7:0]  r_i;
    logic [7:0]  g_i;
    logic [7:0]  b_i;
    logic        start_i;
    logic        pix_ready_i;
    logic [9:0]  pix_x_o;
    logic [8:0]  pix_y_o;
    logic [23:0] pix_color_o;
    logic        pix_valid_o;
    logic        busy_o;
    logic        finished_o;

    modport master (
        output x1_i, y1_i, x2_i, y2_i, r_i, g_i, b_i, start_i, pix_ready_i,
        input  pix_x_o, pix_y_o, pix_color_o, pix_valid_o, busy_o, finished_o
    );

    modport slave (
        input  x1_i, y1_i, x2_i, y2_i, r_i, g_i, b_i, start_i, pix_ready_i,
        output pix_x_o, pix_y_o, pix_color_o, pix_valid_o, busy_o, finished_o
    );
endinterface

// File: rtl/gpu_line_drawer.sv
// Bresenham line rasterizer: latches endpoints and colour, then emits one pixel per
// accepted handshake and pulses finished once the endpoint has been accepted.
module gpu_line_drawer (
    input logic            clk,
    input logic            n_rst,
    gpu_line_drawer_if.slave bus
);
    typedef enum logic [2:0] {IDLE, SETUP, DRAW, DONE, WAIT_LOW} state_t;

    state_t             state_q, state_d;
    logic [9:0]         x1_q, x1_d, x2_q, x2_d;
    logic [8:0]         y1_q, y1_d, y2_q, y2_d;
    logic [23:0]        color_q, color_d;
    logic [9:0]         curX_q, curX_d;
    logic [8:0]         curY_q, curY_d;
    logic signed [10:0] dx_q, dx_d, dy_q, dy_d;
    logic               sxNeg_q, sxNeg_d, syNeg_q, syNeg_d;
    logic signed [11:0] err_q, err_d;
    logic               valid_q, valid_d, busy_q, busy_d, finished_q, finished_d;

    logic signed [12:0] e2;
    logic               stepX, stepY, atEnd, handshake;
    logic [9:0]         xDiff;
    logic [8:0]         yDiff;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q    <= IDLE;
            x1_q       <= '0;
            y1_q       <= '0;
            x2_q       <= '0;
            y2_q       <= '0;
            color_q    <= '0;
            curX_q     <= '0;
            curY_q     <= '0;
            dx_q       <= '0;
            dy_q       <= '0;
            sxNeg_q    <= 1'b0;
            syNeg_q    <= 1'b0;
            err_q      <= '0;
            valid_q    <= 1'b0;
            busy_q     <= 1'b0;
            finished_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            x1_q       <= x1_d;
            y1_q       <= y1_d;
            x2_q       <= x2_d;
            y2_q       <= y2_d;
            color_q    <= color_d;
            curX_q     <= curX_d;
            curY_q     <= curY_d;
            dx_q       <= dx_d;
            dy_q       <= dy_d;
            sxNeg_q    <= sxNeg_d;
            syNeg_q    <= syNeg_d;
            err_q      <= err_d;
            valid_q    <= valid_d;
            busy_q     <= busy_d;
            finished_q <= finished_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        x1_d       = x1_q;
        y1_d       = y1_q;
        x2_d       = x2_q;
        y2_d       = y2_q;
        color_d    = color_q;
        curX_d     = curX_q;
        curY_d     = curY_q;
        dx_d       = dx_q;
        dy_d       = dy_q;
        sxNeg_d    = sxNeg_q;
        syNeg_d    = syNeg_q;
        err_d      = err_q;

        e2        = {err_q, 1'b0};
        stepX     = (e2 >= $signed({{2{dy_q[10]}}, dy_q}));
        stepY     = (e2 <= $signed({{2{dx_q[10]}}, dx_q}));
        atEnd     = (curX_q == x2_q) && (curY_q == y2_q);
        handshake = valid_q && bus.pix_ready_i;
        xDiff     = (x2_q >= x1_q) ? (x2_q - x1_q) : (x1_q - x2_q);
        yDiff     = (y2_q >= y1_q) ? (y2_q - y1_q) : (y1_q - y2_q);

        case (state_q)
            IDLE: begin
                if (bus.start_i) begin
                    x1_d    = bus.x1_i;
                    y1_d    = bus.y1_i;
                    x2_d    = bus.x2_i;
                    y2_d    = bus.y2_i;
                    color_d = {bus.r_i, bus.g_i, bus.b_i};
                    state_d = SETUP;
                end
            end
            SETUP: begin
                dx_d    = $signed({1'b0, xDiff});
                dy_d    = -$signed({2'b00, yDiff});
                sxNeg_d = (x2_q < x1_q);
                syNeg_d = (y2_q < y1_q);
                err_d   = $signed({dx_d[10], dx_d}) + $signed({dy_d[10], dy_d});
                curX_d  = x1_q;
                curY_d  = y1_q;
                state_d = DRAW;
            end
            DRAW: begin
                // Both axis steps may fire together on a diagonal move.
                if (handshake) begin
                    if (atEnd) begin
                        state_d = DONE;
                    end else begin
                        err_d = err_q
                              + (stepX ? $signed({dy_q[10], dy_q}) : 12'sd0)
                              + (stepY ? $signed({dx_q[10], dx_q}) : 12'sd0);
                        if (stepX) curX_d = sxNeg_q ? (curX_q - 10'd1) : (curX_q + 10'd1);
                        if (stepY) curY_d = syNeg_q ? (curY_q - 9'd1) : (curY_q + 9'd1);
                    end
                end
            end
            DONE:     state_d = WAIT_LOW;
            WAIT_LOW: if (!bus.start_i) state_d = IDLE;
            default:  state_d = IDLE;
        endcase

        valid_d    = (state_d == DRAW);
        busy_d     = (state_d != IDLE);
        finished_d = (state_d == DONE);
    end

    assign bus.pix_x_o     = curX_q;
    assign bus.pix_y_o     = curY_q;
    assign bus.pix_color_o = color_q;
    assign bus.pix_valid_o = valid_q;
    assign bus.busy_o      = busy_q;
    assign bus.finished_o  = finished_q;
endmodule
